// File: rtl/pipe_core_bridge_pkg.sv
// Shared types and constants for the pipe/core bridge: FSM states, host word
// width and the layout of the optional status byte in the top result word.
package pipe_core_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WORD_W = 32;

  // Fill counter is wide enough to hold 16 and to supply the 4-bit status nibble.
  localparam int FILL_W = 5;

  // Status byte position within the top result word: {err, busy, 2'b0, fill[3:0]}.
  localparam int STAT_LSB      = 24;
  localparam int STAT_W        = 8;
  localparam int STAT_ERR_BIT  = 7;
  localparam int STAT_BUSY_BIT = 6;
  localparam int STAT_FILL_W   = 4;

endpackage

// File: rtl/pipe_word_unpacker.sv
// Result latch and pipe-out read sequencer: captures the core result on latch
// and serves it one 32-bit word per read, top word first, wrapping.
module pipe_word_unpacker
  import pipe_core_bridge_pkg::*;
#(
  parameter int NOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   latch,
  input  logic [NOUT*WORD_W-1:0] result_in,
  input  logic                   rd,
  output logic [WORD_W-1:0]      data
);

  localparam int RD_IW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [RD_IW-1:0] RD_TOP = RD_IW'(NOUT - 1);

  logic [NOUT*WORD_W-1:0] result;
  logic [RD_IW-1:0]       rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      rd_idx <= RD_TOP;
      data   <= '0;
    end else begin
      if (rd) begin
        data   <= result[int'(rd_idx)*WORD_W +: WORD_W];
        rd_idx <= (rd_idx == '0) ? RD_TOP : rd_idx - 1'b1;
      end
      // A new result restarts the read sequence at the top word.
      if (latch) begin
        result <= result_in;
        rd_idx <= RD_TOP;
      end
    end
  end

endmodule

// File: rtl/pipe_core_bridge.sv
// Host pipe to compute-core bridge: packs pipe-in words into core_din, runs the
// core, and unpacks its result to pipe-out. Option: PIPE_CORE_BRIDGE_STATUS_EN.
module pipe_core_bridge
  import pipe_core_bridge_pkg::*;
#(
  parameter int NIN   = 4,
  parameter int NOUT  = 4,
  parameter int RES_W = 16
) (
  input  logic                  okClk,
  input  logic                  rst,
  input  logic [31:0]           pipe_in_data,
  input  logic                  pipe_in_valid,
  input  logic                  pipe_out_read,
  output logic [31:0]           pipe_out_data,
  input  logic                  start_trig,
  output logic                  done_trig,
  output logic                  busy,
  output logic                  err,
  output logic                  core_start,
  output logic [NIN*32-1:0]     core_din,
  input  logic                  core_done,
  input  logic [RES_W-1:0]      core_dout
);

  localparam int IN_IW    = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int RES_BITS = NOUT * WORD_W;
  localparam logic [IN_IW-1:0]  WR_TOP    = IN_IW'(NIN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NIN);

  state_t                 state;
  logic [IN_IW-1:0]       wr_idx;
  logic [FILL_W-1:0]      fill;
  logic                   start_ok;
  logic                   done_ok;
  logic [RES_BITS-1:0]    result_next;

  // Start is judged on the fill count before any coincident write lands.
  assign start_ok = start_trig && (state == IDLE) && (fill == FILL_FULL);
  assign done_ok  = core_done && (state == RUN);

  always_ff @(posedge okClk) begin
    if (rst) begin
      state      <= IDLE;
      core_din   <= '0;
      wr_idx     <= WR_TOP;
      fill       <= '0;
      core_start <= 1'b0;
      done_trig  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_start <= start_ok;
      done_trig  <= done_ok;
      case (state)
        IDLE: begin
          if (pipe_in_valid) begin
            core_din[int'(wr_idx)*WORD_W +: WORD_W] <= pipe_in_data;
            wr_idx <= (wr_idx == '0) ? WR_TOP : wr_idx - 1'b1;
            if (fill != FILL_FULL) fill <= fill + 1'b1;
          end
          if (start_trig) begin
            if (start_ok) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pipe_in_valid || start_trig) err <= 1'b1;
          if (core_done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            fill   <= '0;
            wr_idx <= WR_TOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_CORE_BRIDGE_STATUS_EN
  localparam int KEEP_W = (RES_W < RES_BITS - STAT_W) ? RES_W : RES_BITS - STAT_W;

  always_comb begin
    result_next = '0;
    result_next[KEEP_W-1:0] = core_dout[KEEP_W-1:0];
    result_next[RES_BITS-WORD_W+STAT_LSB+STAT_ERR_BIT]  = err;
    result_next[RES_BITS-WORD_W+STAT_LSB+STAT_BUSY_BIT] = busy;
    result_next[RES_BITS-WORD_W+STAT_LSB +: STAT_FILL_W] = fill[STAT_FILL_W-1:0];
  end
`else
  always_comb begin
    result_next = '0;
    result_next[RES_W-1:0] = core_dout;
  end
`endif

  pipe_word_unpacker #(
    .NOUT(NOUT)
  ) u_unpacker (
    .clk       (okClk),
    .rst       (rst),
    .latch     (done_ok),
    .result_in (result_next),
    .rd        (pipe_out_read),
    .data      (pipe_out_data)
  );

endmodule

// File: tb/tb_pipe_core_bridge.sv
// Scoreboard bench for pipe_core_bridge (NIN=NOUT=4, RES_W=16, default build):
// expected pulses/read data are queued by stimulus and checked by a monitor.
module tb_pipe_core_bridge;

  logic          okClk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pipe_in_data = '0;
  logic          pipe_in_valid = 1'b0;
  logic          pipe_out_read = 1'b0;
  logic [31:0]   pipe_out_data;
  logic          start_trig = 1'b0;
  logic          done_trig;
  logic          busy;
  logic          err;
  logic          core_start;
  logic [127:0]  core_din;
  logic          core_done = 1'b0;
  logic [15:0]   core_dout = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic rd_q = 1'b0;

  int          q_start[$];
  int          q_done[$];
  logic [31:0] q_rd[$];

  pipe_core_bridge #(
    .NIN(4),
    .NOUT(4),
    .RES_W(16)
  ) dut (
    .okClk         (okClk),
    .rst           (rst),
    .pipe_in_data  (pipe_in_data),
    .pipe_in_valid (pipe_in_valid),
    .pipe_out_read (pipe_out_read),
    .pipe_out_data (pipe_out_data),
    .start_trig    (start_trig),
    .done_trig     (done_trig),
    .busy          (busy),
    .err           (err),
    .core_start    (core_start),
    .core_din      (core_din),
    .core_done     (core_done),
    .core_dout     (core_dout)
  );

  always #5 okClk = ~okClk;

  always @(posedge okClk) begin
    cyc  <= cyc + 1;
    rd_q <= pipe_out_read;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed pulse or read return is matched against the queues.
  initial begin
    forever begin
      @(negedge okClk);
      if (core_start) begin
        if (q_start.size() == 0) chk("core_start_unexpected", 128'(cyc), 128'hFFFF_FFFF);
        else chk("core_start_cycle", 128'(cyc), 128'(q_start.pop_front()));
      end
      if (done_trig) begin
        if (q_done.size() == 0) chk("done_trig_unexpected", 128'(cyc), 128'hFFFF_FFFF);
        else chk("done_trig_cycle", 128'(cyc), 128'(q_done.pop_front()));
      end
      if (rd_q) begin
        if (q_rd.size() == 0) chk("read_unexpected", 128'(pipe_out_data), 128'hDEAD_0000_0000);
        else chk("read_data", 128'(pipe_out_data), 128'(q_rd.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    pipe_in_data  = d;
    pipe_in_valid = 1'b1;
    tick();
    pipe_in_valid = 1'b0;
  endtask

  task automatic start(input bit expect_accept);
    start_trig = 1'b1;
    if (expect_accept) q_start.push_back(cyc + 1);
    tick();
    start_trig = 1'b0;
  endtask

  task automatic finish_core(input logic [15:0] val, input bit expect_done);
    core_dout = val;
    core_done = 1'b1;
    if (expect_done) q_done.push_back(cyc + 1);
    tick();
    core_done = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] exp);
    pipe_out_read = 1'b1;
    q_rd.push_back(exp);
    tick();
    pipe_out_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("reset_core_din", core_din, '0);
    chk("reset_err", 128'(err), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_pipe_out", 128'(pipe_out_data), 128'(0));

    // core_done while idle is ignored
    finish_core(16'h1111, 1'b0);
    tick();
    chk("idle_done_busy", 128'(busy), 128'(0));

    // pack four words, top word first
    for (int i = 1; i <= 4; i++) write_word(32'(i));
    chk("pack_core_din", core_din, 128'h00000001_00000002_00000003_00000004);
    start(1'b1);
    chk("run_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 9; i++) tick();
    finish_core(16'hBEEF, 1'b1);
    tick();
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_err", 128'(err), 128'(0));
    read_word(32'h0);
    read_word(32'h0);
    read_word(32'h0);
    read_word(32'h0000BEEF);
    tick();
    tick();
    chk("read_hold", 128'(pipe_out_data), 128'h0000BEEF);

    // start with an underfilled buffer is rejected
    do_reset();
    for (int i = 1; i <= 3; i++) write_word(32'(i));
    start(1'b0);
    tick();
    chk("short_start_err", 128'(err), 128'(1));
    chk("short_start_busy", 128'(busy), 128'(0));

    // write and start together at fill 3: write lands, start rejected
    do_reset();
    for (int i = 1; i <= 3; i++) write_word(32'(i));
    pipe_in_data  = 32'h4;
    pipe_in_valid = 1'b1;
    start(1'b0);
    pipe_in_valid = 1'b0;
    chk("coincide_core_din", core_din, 128'h00000001_00000002_00000003_00000004);
    chk("coincide_err", 128'(err), 128'(1));
    chk("coincide_busy", 128'(busy), 128'(0));
    start(1'b1);
    chk("coincide_restart_busy", 128'(busy), 128'(1));

    // overfill wraps: six writes overwrite the top two words
    do_reset();
    for (int i = 1; i <= 6; i++) write_word(32'(i));
    chk("wrap_core_din", core_din, 128'h00000005_00000006_00000003_00000004);
    start(1'b1);
    chk("wrap_start_busy", 128'(busy), 128'(1));
    chk("wrap_start_err", 128'(err), 128'(0));

    // write during RUN is dropped and flagged
    write_word(32'h77);
    chk("run_write_core_din", core_din, 128'h00000005_00000006_00000003_00000004);
    chk("run_write_err", 128'(err), 128'(1));

    // reset mid-RUN, then a late core_done is ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    finish_core(16'hABCD, 1'b0);
    tick();
    chk("abort_core_din", core_din, '0);
    chk("abort_err", 128'(err), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_pipe_out", 128'(pipe_out_data), 128'(0));
    chk("abort_done_trig", 128'(done_trig), 128'(0));

    // read index wraps after NOUT reads
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'hA0 + 32'(i));
    start(1'b1);
    tick();
    finish_core(16'h1234, 1'b1);
    for (int i = 0; i < 8; i++) read_word((i % 4 == 3) ? 32'h00001234 : 32'h0);

    for (int i = 0; i < 4; i++) tick();
    chk("start_queue_drained", 128'(q_start.size()), 128'(0));
    chk("done_queue_drained", 128'(q_done.size()), 128'(0));
    chk("read_queue_drained", 128'(q_rd.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
